// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/func3 encodings, widths, engine state and ALU helpers
package alu_pkg;
  localparam int XLEN = 32;
  localparam int ROB_POS_WID = 4;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_REM    = 3'd6;

  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_DONE} md_state_t;

  // alt selects SUB for ADD and arithmetic shift for the right shifts
  function automatic logic [XLEN-1:0] arith(input logic [2:0] f3, input logic alt,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] sra;
    sra = $signed(a) >>> b[4:0];
    case (f3)
      F3_ADD:  arith = alt ? a - b : a + b;
      F3_SLL:  arith = a << b[4:0];
      F3_SLT:  arith = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      F3_SLTU: arith = {{(XLEN-1){1'b0}}, a < b};
      F3_XOR:  arith = a ^ b;
      F3_SR:   arith = alt ? sra : a >> b[4:0];
      F3_OR:   arith = a | b;
      default: arith = a & b;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
    case (f3)
      F3_BEQ:  branch_taken = a == b;
      F3_BNE:  branch_taken = a != b;
      F3_BLT:  branch_taken = $signed(a) < $signed(b);
      F3_BGE:  branch_taken = $signed(a) >= $signed(b);
      F3_BLTU: branch_taken = a < b;
      F3_BGEU: branch_taken = a >= b;
      default: branch_taken = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M engine, one multiplier/quotient bit per cycle on magnitudes
module alu_muldiv
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            rollback,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] value
);
  md_state_t state, state_nx;
  logic [4:0] cnt;
  logic [2:0] op_q;
  logic neg_q, neg_r, dz;
  logic [2*XLEN-1:0] acc, mcand, mul_next, div_next, prod;
  logic [XLEN-1:0] opb, mag_a, mag_b, quo, rem;
  logic [XLEN+1:0] trial;
  logic sgn_a, sgn_b, ge;

  assign sgn_a = (op inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) && a[XLEN-1];
  assign sgn_b = (op inside {F3_MULH, F3_DIV, F3_REM}) && b[XLEN-1];
  assign mag_a = sgn_a ? -a : a;
  assign mag_b = sgn_b ? -b : b;
  assign mul_next = opb[0] ? acc + mcand : acc;
  assign trial = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b0, opb};
  assign ge = ~trial[XLEN+1];
  assign div_next = {ge ? trial[XLEN-1:0] : acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], ge};

  // state register; rdy low freezes the engine
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= MD_IDLE;
    else if (rdy) state <= state_nx;

  // next state: 32 CALC cycles, then a single DONE cycle; rollback aborts from anywhere
  always_comb begin
    state_nx = state;
    if (rollback) state_nx = MD_IDLE;
    else
      case (state)
        MD_IDLE: state_nx = start ? MD_CALC : MD_IDLE;
        MD_CALC: state_nx = (cnt == 5'd31) ? MD_DONE : MD_CALC;
        default: state_nx = MD_IDLE;
      endcase
  end

  // datapath: load magnitudes on start, then shift-add or restoring-divide step per cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      op_q <= '0;
      acc <= '0;
      mcand <= '0;
      opb <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
    end else if (rdy) begin
      if (rollback) cnt <= '0;
      else if (state == MD_IDLE && start) begin
        cnt <= '0;
        op_q <= op;
        acc <= op[2] ? {{XLEN{1'b0}}, mag_a} : '0;
        mcand <= {{XLEN{1'b0}}, mag_a};
        opb <= mag_b;
        neg_q <= sgn_a ^ sgn_b;
        neg_r <= sgn_a;
        dz <= b == '0;
      end else if (state == MD_CALC) begin
        cnt <= cnt + 5'd1;
        acc <= op_q[2] ? div_next : mul_next;
        mcand <= mcand << 1;
        opb <= op_q[2] ? opb : opb >> 1;
      end
    end

  // outputs: signs restored here; a zero divisor keeps the all-ones quotient unsigned
  always_comb begin
    busy = state != MD_IDLE;
    done = state == MD_DONE;
    prod = neg_q ? -acc : acc;
    quo = dz ? '1 : neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    value = (op_q == F3_MUL) ? prod[XLEN-1:0] : !op_q[2] ? prod[2*XLEN-1:XLEN] : op_q[1] ? rem : quo;
  end
endmodule

// File: rtl/alu.sv
// alu: RV32IM execution unit with single-cycle integer ops and an iterative mul/div engine
module alu
  import alu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   alu_en,
  input  logic [6:0]             alu_opcode,
  input  logic [2:0]             alu_func3,
  input  logic                   alu_func7,
  input  logic                   alu_mext,
  input  logic [XLEN-1:0]        alu_val1,
  input  logic [XLEN-1:0]        alu_val2,
  input  logic [XLEN-1:0]        alu_imm,
  input  logic [XLEN-1:0]        alu_pc,
  input  logic [ROB_POS_WID-1:0] alu_rob_pos,
  output logic                   alu_busy,
  output logic                   alu_result,
  output logic [ROB_POS_WID-1:0] alu_result_rob_pos,
  output logic [XLEN-1:0]        alu_result_val,
  output logic                   alu_result_jump,
  output logic [XLEN-1:0]        alu_result_pc
);
  logic is_md, accept, md_start, md_busy, md_done, taken, sc_jump;
  logic [XLEN-1:0] md_value, pc4, sc_val, sc_npc, md_npc;
  logic [ROB_POS_WID-1:0] md_rob;

  assign is_md = alu_opcode == OP_REG && alu_mext;
  assign accept = alu_en && !alu_busy && !rollback;
  assign md_start = accept && is_md;
  assign alu_busy = md_busy;
  assign pc4 = alu_pc + 32'd4;
  assign taken = branch_taken(alu_func3, alu_val1, alu_val2);

  alu_muldiv u_muldiv (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .rollback(rollback),
    .start(md_start),
    .op(alu_func3),
    .a(alu_val1),
    .b(alu_val2),
    .busy(md_busy),
    .done(md_done),
    .value(md_value)
  );

  // single-cycle result; ADDI never turns into a subtract
  always_comb begin
    sc_val = '0;
    sc_jump = 1'b0;
    sc_npc = pc4;
    case (alu_opcode)
      OP_LUI:    sc_val = alu_imm;
      OP_AUIPC:  sc_val = alu_pc + alu_imm;
      OP_JAL: begin
        sc_val = pc4;
        sc_jump = 1'b1;
        sc_npc = alu_pc + alu_imm;
      end
      OP_JALR: begin
        sc_val = pc4;
        sc_jump = 1'b1;
        sc_npc = (alu_val1 + alu_imm) & ~32'd1;
      end
      OP_BRANCH: begin
        sc_jump = taken;
        sc_npc = taken ? alu_pc + alu_imm : pc4;
      end
      OP_IMM:    sc_val = arith(alu_func3, alu_func3 == F3_SR && alu_func7, alu_val1, alu_imm);
      OP_REG:    sc_val = arith(alu_func3, alu_func7, alu_val1, alu_val2);
      default:   sc_val = '0;
    endcase
  end

  // broadcast register: rollback squashes, then engine completion, then a new single-cycle op
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      alu_result <= 1'b0;
      alu_result_rob_pos <= '0;
      alu_result_val <= '0;
      alu_result_jump <= 1'b0;
      alu_result_pc <= '0;
      md_rob <= '0;
      md_npc <= '0;
    end else if (rdy) begin
      if (md_start) begin
        md_rob <= alu_rob_pos;
        md_npc <= pc4;
      end
      if (rollback) alu_result <= 1'b0;
      else if (md_done) begin
        alu_result <= 1'b1;
        alu_result_rob_pos <= md_rob;
        alu_result_val <= md_value;
        alu_result_jump <= 1'b0;
        alu_result_pc <= md_npc;
      end else if (accept && !is_md) begin
        alu_result <= 1'b1;
        alu_result_rob_pos <= alu_rob_pos;
        alu_result_val <= sc_val;
        alu_result_jump <= sc_jump;
        alu_result_pc <= sc_npc;
      end else alu_result <= 1'b0;
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed checks of the ALU against a behavioural model
module tb_alu;
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_IMM = 7'b0010011,
                         OPC_OP = 7'b0110011;

  typedef struct packed {
    logic [31:0] val;
    logic        jump;
    logic [31:0] npc;
  } exp_t;

  logic clk = 0, rst = 0, rdy = 1, rollback = 0, alu_en = 0, alu_func7 = 0, alu_mext = 0;
  logic [6:0] alu_opcode = 0;
  logic [2:0] alu_func3 = 0;
  logic [31:0] alu_val1 = 0, alu_val2 = 0, alu_imm = 0, alu_pc = 0;
  logic [3:0] alu_rob_pos = 0;
  logic alu_busy, alu_result, alu_result_jump;
  logic [3:0] alu_result_rob_pos;
  logic [31:0] alu_result_val, alu_result_pc;
  int passed = 0, total = 0;
  logic [6:0] ops [7] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR, OPC_IMM, OPC_OP};
  logic [2:0] brs [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  alu dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
    .alu_opcode(alu_opcode), .alu_func3(alu_func3), .alu_func7(alu_func7), .alu_mext(alu_mext),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_rob_pos(alu_rob_pos), .alu_busy(alu_busy), .alu_result(alu_result),
    .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
    .alu_result_jump(alu_result_jump), .alu_result_pc(alu_result_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic exp_t model_single(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                        input logic [31:0] v1, v2, imm, pc);
    exp_t e;
    logic [31:0] b;
    logic t;
    longint sv1;
    e.val = 0;
    e.jump = 0;
    e.npc = pc + 4;
    b = (op == OPC_OP) ? v2 : imm;
    sv1 = longint'($signed(v1));
    t = 0;
    case (op)
      OPC_LUI: e.val = imm;
      OPC_AUIPC: e.val = pc + imm;
      OPC_JAL: begin e.val = pc + 4; e.jump = 1; e.npc = pc + imm; end
      OPC_JALR: begin e.val = pc + 4; e.jump = 1; e.npc = (v1 + imm) & 32'hFFFFFFFE; end
      OPC_BR: begin
        case (f3)
          0: t = v1 == v2;
          1: t = v1 != v2;
          4: t = $signed(v1) < $signed(v2);
          5: t = $signed(v1) >= $signed(v2);
          6: t = v1 < v2;
          default: t = v1 >= v2;
        endcase
        e.jump = t;
        e.npc = t ? pc + imm : pc + 4;
      end
      default:
        case (f3)
          0: e.val = (op == OPC_OP && f7) ? v1 - b : v1 + b;
          1: e.val = v1 << b[4:0];
          2: e.val = {31'b0, $signed(v1) < $signed(b)};
          3: e.val = {31'b0, v1 < b};
          4: e.val = v1 ^ b;
          5: e.val = f7 ? 32'(sv1 >>> b[4:0]) : v1 >> b[4:0];
          6: e.val = v1 | b;
          default: e.val = v1 & b;
        endcase
    endcase
    return e;
  endfunction

  function automatic logic [31:0] model_md(input logic [2:0] f3, input logic [31:0] a, b);
    longint sa, sb;
    logic [63:0] up;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    ovf = a == 32'h80000000 && b == 32'hFFFFFFFF;
    case (f3)
      0: return 32'(sa * sb);
      1: return 32'((sa * sb) >>> 32);
      2: return 32'((sa * longint'({32'b0, b})) >>> 32);
      3: return up[63:32];
      4: return b == 0 ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'(sa / sb);
      5: return b == 0 ? 32'hFFFFFFFF : a / b;
      6: return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic mx,
                       input logic [31:0] v1, v2, imm, pc, input logic [3:0] rob);
    alu_opcode = op; alu_func3 = f3; alu_func7 = f7; alu_mext = mx;
    alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc; alu_rob_pos = rob;
    alu_en = 1;
  endtask

  task automatic dispatch(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic mx,
                          input logic [31:0] v1, v2, imm, pc, input logic [3:0] rob);
    drive(op, f3, f7, mx, v1, v2, imm, pc, rob);
    step();
    alu_en = 0;
  endtask

  task automatic wait_md(output int lat, output int bc);
    lat = 0;
    bc = 0;
    while (!alu_result && lat < 40) begin
      if (alu_busy) bc++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    int seen;
    step();
    step();
    total++;
    if ({alu_result, alu_result_val, alu_result_jump, alu_result_pc, alu_result_rob_pos, alu_busy} !== 71'b0) begin
      $display("FAIL reset_state: got %b/%h/%b/%h/%h busy=%b required all zero", alu_result, alu_result_val,
               alu_result_jump, alu_result_pc, alu_result_rob_pos, alu_busy);
    end else passed++;
    rst = 1;
    step();
    dispatch(OPC_OP, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 32'h10, 4'd7);
    total++;
    if (alu_result !== 1'b1) $display("FAIL reset_pre_result: got %b required 1", alu_result);
    else passed++;
    #2 rst = 0;
    #1;
    total++;
    if ({alu_result, alu_result_val, alu_result_pc, alu_result_rob_pos} !== 69'b0)
      $display("FAIL async_reset: got %b/%h/%h/%h required all zero", alu_result, alu_result_val,
               alu_result_pc, alu_result_rob_pos);
    else passed++;
    #2 rst = 1;
    step();
    dispatch(OPC_OP, 3'd4, 1'b0, 1'b1, 32'd100, 32'd3, 32'd0, 32'h0, 4'd2);
    for (int i = 0; i < 5; i++) step();
    #2 rst = 0;
    #1;
    total++;
    if (alu_busy !== 1'b0) $display("FAIL reset_mid_busy: got %b required 0", alu_busy);
    else passed++;
    rst = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (alu_result) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL reset_mid_no_result: got %0d results required 0", seen);
    else passed++;
  endtask

  task automatic test_directed();
    dispatch(OPC_OP, 3'd0, 1'b0, 1'b0, 32'd5, 32'hFFFFFFF9, 32'd0, 32'h0, 4'd3);
    total++;
    if ({alu_result, alu_result_val, alu_result_rob_pos, alu_result_jump} !== {1'b1, 32'hFFFFFFFE, 4'd3, 1'b0})
      $display("FAIL add: got %b/%h/%h/%b required 1/fffffffe/3/0", alu_result, alu_result_val,
               alu_result_rob_pos, alu_result_jump);
    else passed++;
    step();
    total++;
    if (alu_result !== 1'b0) $display("FAIL add_one_cycle: got %b required 0", alu_result);
    else passed++;
    dispatch(OPC_BR, 3'd4, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd1);
    total++;
    if ({alu_result_jump, alu_result_pc, alu_result_val} !== {1'b1, 32'h120, 32'h0})
      $display("FAIL blt_taken: got %b/%h/%h required 1/120/0", alu_result_jump, alu_result_pc, alu_result_val);
    else passed++;
    dispatch(OPC_BR, 3'd4, 1'b0, 1'b0, 32'd1, 32'hFFFFFFFF, 32'h20, 32'h100, 4'd1);
    total++;
    if ({alu_result_jump, alu_result_pc} !== {1'b0, 32'h104})
      $display("FAIL blt_not_taken: got %b/%h required 0/104", alu_result_jump, alu_result_pc);
    else passed++;
    dispatch(OPC_JALR, 3'd0, 1'b0, 1'b0, 32'h1003, 32'd0, 32'd4, 32'h40, 4'd9);
    total++;
    if ({alu_result_val, alu_result_pc, alu_result_jump} !== {32'h44, 32'h1006, 1'b1})
      $display("FAIL jalr: got %h/%h/%b required 44/1006/1", alu_result_val, alu_result_pc, alu_result_jump);
    else passed++;
    dispatch(OPC_IMM, 3'd0, 1'b1, 1'b0, 32'd10, 32'd0, 32'd3, 32'h0, 4'd0);
    total++;
    if (alu_result_val !== 32'd13) $display("FAIL addi_ignores_f7: got %h required d", alu_result_val);
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    logic [31:0] v1, v2, imm, pc;
    logic [3:0] rob;
    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 6)];
      f3 = (op == OPC_BR) ? brs[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      v1 = rnd32(); v2 = rnd32(); imm = rnd32(); pc = $urandom; rob = 4'($urandom);
      e = model_single(op, f3, f7, v1, v2, imm, pc);
      drive(op, f3, f7, 1'b0, v1, v2, imm, pc, rob);
      step();
      total++;
      if ({alu_result, alu_result_val, alu_result_jump, alu_result_pc, alu_result_rob_pos} !==
          {1'b1, e.val, e.jump, e.npc, rob})
        $display("FAIL random_single op=%b f3=%0d: got %b/%h/%b/%h/%h required 1/%h/%b/%h/%h", op, f3,
                 alu_result, alu_result_val, alu_result_jump, alu_result_pc, alu_result_rob_pos,
                 e.val, e.jump, e.npc, rob);
      else passed++;
    end
    alu_en = 0;
    step();
    total++;
    if (alu_result !== 1'b0) $display("FAIL random_idle: got %b required 0", alu_result);
    else passed++;
  endtask

  task automatic test_muldiv_directed();
    logic [2:0] f3s [6] = '{3'd4, 3'd5, 3'd6, 3'd4, 3'd6, 3'd6};
    logic [31:0] as [6] = '{32'h80000000, 32'd7, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000};
    logic [31:0] bs [6] = '{32'hFFFFFFFF, 32'd0, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
    logic [31:0] xs [6] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd0};
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      dispatch(OPC_OP, f3s[i], 1'b0, 1'b1, as[i], bs[i], 32'd0, 32'h200, 4'(i + 6));
      wait_md(lat, bc);
      total++;
      if ({lat, bc} !== {32'd33, 32'd33})
        $display("FAIL md_timing_%0d: got latency %0d busy %0d required 33/33", i, lat, bc);
      else passed++;
      total++;
      if ({alu_result_val, alu_result_rob_pos, alu_result_jump, alu_result_pc, alu_busy} !==
          {xs[i], 4'(i + 6), 1'b0, 32'h204, 1'b0})
        $display("FAIL md_value_%0d: got %h/%h/%b/%h busy=%b required %h/%h/0/204/0", i, alu_result_val,
                 alu_result_rob_pos, alu_result_jump, alu_result_pc, alu_busy, xs[i], 4'(i + 6));
      else passed++;
    end
  endtask

  task automatic test_muldiv_random();
    logic [2:0] f3;
    logic [31:0] a, b, x;
    logic [3:0] rob;
    int lat, bc;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = rnd32(); b = rnd32(); rob = 4'($urandom);
      x = model_md(f3, a, b);
      dispatch(OPC_OP, f3, 1'b0, 1'b1, a, b, 32'd0, 32'h0, rob);
      wait_md(lat, bc);
      total++;
      if ({lat, alu_result_val, alu_result_rob_pos} !== {32'd33, x, rob})
        $display("FAIL md_random f3=%0d a=%h b=%h: got lat %0d val %h rob %h required 33/%h/%h", f3, a, b,
                 lat, alu_result_val, alu_result_rob_pos, x, rob);
      else passed++;
    end
  endtask

  task automatic test_stall();
    int lat, bc;
    logic early;
    dispatch(OPC_OP, 3'd1, 1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'd0, 32'h0, 4'd11);
    early = 0;
    for (int i = 0; i < 10; i++) begin step(); if (alu_result) early = 1; end
    rdy = 0;
    for (int i = 0; i < 5; i++) begin step(); if (alu_result || !alu_busy) early = 1; end
    rdy = 1;
    wait_md(lat, bc);
    total++;
    if ({early, lat + 15, alu_result_val, alu_result_rob_pos} !== {1'b0, 32'd38, 32'h40000000, 4'd11})
      $display("FAIL mulh_stall: got early=%b lat %0d val %h rob %h required 0/38/40000000/b", early,
               lat + 15, alu_result_val, alu_result_rob_pos);
    else passed++;
    step();
    dispatch(OPC_OP, 3'd0, 1'b0, 1'b0, 32'd20, 32'd22, 32'd0, 32'h0, 4'd5);
    rdy = 0;
    step();
    total++;
    if ({alu_result, alu_result_val} !== {1'b1, 32'd42})
      $display("FAIL rdy_hold: got %b/%h required 1/2a", alu_result, alu_result_val);
    else passed++;
    rdy = 1;
    step();
    total++;
    if (alu_result !== 1'b0) $display("FAIL rdy_release: got %b required 0", alu_result);
    else passed++;
  endtask

  task automatic test_rollback();
    int seen;
    dispatch(OPC_OP, 3'd3, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h0, 4'd8);
    for (int i = 0; i < 9; i++) step();
    rollback = 1;
    step();
    rollback = 0;
    total++;
    if ({alu_busy, alu_result} !== 2'b00)
      $display("FAIL rollback_abort: got busy=%b result=%b required 0/0", alu_busy, alu_result);
    else passed++;
    dispatch(OPC_OP, 3'd0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd0, 32'h0, 4'd4);
    total++;
    if ({alu_result, alu_result_val, alu_result_rob_pos} !== {1'b1, 32'd5, 4'd4})
      $display("FAIL rollback_then_add: got %b/%h/%h required 1/5/4", alu_result, alu_result_val,
               alu_result_rob_pos);
    else passed++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin step(); if (alu_result) seen++; end
    total++;
    if (seen != 0) $display("FAIL rollback_no_late_result: got %0d results required 0", seen);
    else passed++;
    drive(OPC_OP, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 32'h0, 4'd1);
    rollback = 1;
    step();
    rollback = 0;
    alu_en = 0;
    total++;
    if (alu_result !== 1'b0) $display("FAIL rollback_drops_dispatch: got %b required 0", alu_result);
    else passed++;
  endtask

  task automatic test_busy_ignore();
    int lat, bc;
    logic early;
    dispatch(OPC_OP, 3'd4, 1'b0, 1'b1, 32'd100, 32'd7, 32'd0, 32'h0, 4'd5);
    drive(OPC_OP, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 32'h0, 4'd9);
    early = 0;
    for (int i = 0; i < 3; i++) begin step(); if (alu_result) early = 1; end
    alu_en = 0;
    wait_md(lat, bc);
    total++;
    if ({early, lat + 3, alu_result_val, alu_result_rob_pos} !== {1'b0, 32'd33, 32'd14, 4'd5})
      $display("FAIL busy_ignore: got early=%b lat %0d val %h rob %h required 0/33/e/5", early, lat + 3,
               alu_result_val, alu_result_rob_pos);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_muldiv_directed();
    test_muldiv_random();
    test_stall();
    test_rollback();
    test_busy_ignore();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; every register samples on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port rdy, input, 1, global enable; when 0, all state holds.
REQ-004 SHALL have port rollback, input, 1, a misprediction flush.
REQ-005 SHALL have dispatch inputs from RS: alu_en 1, alu_opcode 7, alu_func3 3, alu_func7 1 (instr bit 30), alu_mext 1 (instr bit 25), alu_val1 32, alu_val2 32, alu_imm 32, alu_pc 32, alu_rob_pos 4.
REQ-006 SHALL have output alu_busy, 1, combinational; high while a MUL/DIV is iterating; RS SHALL NOT dispatch while it is high.
REQ-007 SHALL have outputs alu_result 1, alu_result_rob_pos 4, alu_result_val 32, alu_result_jump 1 (branch/jump redirect), alu_result_pc 32 (resolved next PC); this is the broadcast to RS, LSB and ROB.

Function
REQ-008 SHALL support opcodes LUI, AUIPC, JAL, JALR, BRANCH, OP-IMM, OP (RV32I) plus OP with alu_mext=1 (RV32M).
REQ-009 Single-cycle ops SHALL assert alu_result for exactly one cycle, on the edge following the edge where alu_en was sampled high.
REQ-010 OP/OP-IMM SHALL use operand 2 = val2 (OP) or imm (OP-IMM); SUB/SRA are selected by func7, except OP-IMM ADDI, which SHALL ignore func7; shift amount = operand2[4:0].
REQ-011 LUI SHALL yield imm; AUIPC SHALL yield pc+imm; both with jump=0 and result_pc=pc+4.
REQ-012 JAL SHALL yield val=pc+4, jump=1, result_pc=pc+imm; JALR SHALL yield val=pc+4, jump=1, result_pc=(val1+imm)&~1.
REQ-013 BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU) SHALL yield val=0, jump=condition, result_pc = condition ? pc+imm : pc+4.
REQ-014 MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU SHALL run iteratively: IDLE -> CALC (32 cycles, one bit per cycle) -> DONE (result asserted one cycle) -> IDLE.
REQ-015 Latency from accepting edge to alu_result high SHALL be 33 cycles; alu_busy SHALL be high from the accepting edge until the DONE cycle inclusive.
REQ-016 Signed operands SHALL be converted to magnitudes before iteration, with the sign fixed in DONE.
REQ-017 Division by zero SHALL return quotient 0xFFFFFFFF and remainder = dividend.
REQ-018 Signed overflow (0x80000000 / -1) SHALL return quotient 0x80000000 and remainder 0.
REQ-019 alu_en SHALL be ignored while alu_busy=1 (RS contract violation).
REQ-020 rollback SHALL, on the next edge, abort any iteration, return to IDLE, and force alu_result=0; a dispatch in the same cycle SHALL be dropped.
REQ-021 With rdy=0, no output, counter or state SHALL change; the iteration resumes when rdy returns.
REQ-022 alu_result_rob_pos SHALL equal the rob_pos captured at dispatch, including for MUL/DIV.

Reset
REQ-023 On rst=0, the block SHALL asynchronously clear alu_result, alu_result_jump, alu_result_val, alu_result_pc and alu_result_rob_pos to 0, set state IDLE, set the counter to 0, and deassert alu_busy.
REQ-024 Reset mid-iteration SHALL discard the operation with no result broadcast.

Structure
REQ-025 Opcode, func3 encodings, width macros and ROB_POS_WID SHALL live in the shared cons.v include; no local literals SHALL be used for them.
REQ-026 The iterative engine SHALL be a sub-module alu_muldiv (start, op, a, b -> done, value), instantiated once; the state machine and counter SHALL live there.

Verification
REQ-027 ADD: val1=5, val2=-7, rob_pos=3 -> next cycle result=1, val=0xFFFFFFFE, rob_pos=3, jump=0.
REQ-028 BLT: val1=-1, val2=1, pc=0x100, imm=0x20 -> jump=1, result_pc=0x120; swap the operands -> jump=0, result_pc=0x104.
REQ-029 JALR: pc=0x40, val1=0x1003, imm=4 -> val=0x44, result_pc=0x1006, jump=1.
REQ-030 DIV: 0x80000000/0xFFFFFFFF -> after 33 cycles val=0x80000000; busy is high for 33 cycles; DIVU 7/0 -> 0xFFFFFFFF; REM -7/2 -> 0xFFFFFFFF.
REQ-031 MULH: 0x80000000 * 0x80000000 -> val=0x40000000; hold rdy=0 for 5 cycles mid-iteration -> result arrives 5 cycles later with the same value.
REQ-032 Start MULHU, assert rollback at cycle 10 -> no alu_result, busy low next cycle; an ADD issued the following cycle completes normally.
